// File: rtl/traffic_generator_burst_scheduler_if.sv
// Request/acknowledge/end-of-frame handshake between the burst scheduler
// (master) and the GMII frame emitter (slave).
interface traffic_generator_burst_scheduler_if;
  logic frame_req;
  logic frame_ack;
  logic frame_done;

  modport master (
    output frame_req,
    input  frame_ack,
    input  frame_done
  );

  modport slave (
    input  frame_req,
    output frame_ack,
    output frame_done
  );
endinterface

// File: rtl/traffic_generator_burst_scheduler.sv
// Sequences frame emissions into bursts with interframe/interburst gaps and
// exposes run progress counters for CPU readback.
module traffic_generator_burst_scheduler #(
  parameter int C_GAP_WIDTH   = 32,
  parameter int C_COUNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     run,
  input  logic [C_GAP_WIDTH-1:0]   interframe_gap,
  input  logic [C_GAP_WIDTH-1:0]   interburst_gap,
  input  logic [C_COUNT_WIDTH-1:0] frames_per_burst,
  input  logic [C_COUNT_WIDTH-1:0] total_frames,
  traffic_generator_burst_scheduler_if.master emit,
  output logic                     busy,
  output logic                     done,
  output logic [C_COUNT_WIDTH-1:0] frames_sent,
  output logic [C_COUNT_WIDTH-1:0] bursts_sent,
  output logic                     protocol_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [C_COUNT_WIDTH-1:0] CNT_ONE = {{(C_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_GAP_WIDTH-1:0]   GAP_ONE = {{(C_GAP_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_reg, state_next;
  logic [C_GAP_WIDTH-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [C_GAP_WIDTH-1:0]   ifg_reg, ifg_next;
  logic [C_GAP_WIDTH-1:0]   ibg_reg, ibg_next;
  logic [C_COUNT_WIDTH-1:0] fpb_reg, fpb_next;
  logic [C_COUNT_WIDTH-1:0] total_reg, total_next;
  logic [C_COUNT_WIDTH-1:0] frames_reg, frames_next;
  logic [C_COUNT_WIDTH-1:0] bursts_reg, bursts_next;
  logic [C_COUNT_WIDTH-1:0] burst_cnt_reg, burst_cnt_next;
  logic                     err_reg, err_next;

  logic [C_COUNT_WIDTH-1:0] frames_inc;
  logic [C_COUNT_WIDTH-1:0] burst_cnt_inc;
  logic                     last_frame;
  logic                     burst_end;
  logic [C_GAP_WIDTH-1:0]   gap_sel;

  assign frames_inc    = frames_reg + CNT_ONE;
  assign burst_cnt_inc = burst_cnt_reg + CNT_ONE;
  assign last_frame    = (total_reg != '0) && (frames_inc == total_reg);
  assign burst_end     = (fpb_reg != '0) && (burst_cnt_inc == fpb_reg);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      gap_cnt_reg   <= '0;
      ifg_reg       <= '0;
      ibg_reg       <= '0;
      fpb_reg       <= '0;
      total_reg     <= '0;
      frames_reg    <= '0;
      bursts_reg    <= '0;
      burst_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      ifg_reg       <= ifg_next;
      ibg_reg       <= ibg_next;
      fpb_reg       <= fpb_next;
      total_reg     <= total_next;
      frames_reg    <= frames_next;
      bursts_reg    <= bursts_next;
      burst_cnt_reg <= burst_cnt_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    ifg_next       = ifg_reg;
    ibg_next       = ibg_reg;
    fpb_next       = fpb_reg;
    total_next     = total_reg;
    frames_next    = frames_reg;
    bursts_next    = bursts_reg;
    burst_cnt_next = burst_cnt_reg;
    gap_sel        = ifg_reg;
    // Handshake pulses arriving in the wrong state are flagged and otherwise dropped.
    err_next = err_reg
             | (emit.frame_ack  && (state_reg != ST_REQ))
             | (emit.frame_done && (state_reg != ST_WAIT_DONE));

    case (state_reg)
      ST_IDLE: begin
        if (run) begin
          ifg_next       = interframe_gap;
          ibg_next       = interburst_gap;
          fpb_next       = frames_per_burst;
          total_next     = total_frames;
          frames_next    = '0;
          bursts_next    = '0;
          burst_cnt_next = '0;
          err_next       = 1'b0;
          state_next     = ST_REQ;
        end
      end

      ST_REQ: begin
        if (emit.frame_ack) begin
          state_next = ST_WAIT_DONE;
        end else if (!run) begin
          state_next = ST_IDLE;
        end
      end

      ST_WAIT_DONE: begin
        if (emit.frame_done) begin
          frames_next = frames_inc;
          if (last_frame) begin
            // Final frame still closes its burst, but no trailing gap.
            if (burst_end) begin
              bursts_next    = bursts_reg + CNT_ONE;
              burst_cnt_next = '0;
            end
            state_next = ST_DONE;
          end else if (!run) begin
            state_next = ST_IDLE;
          end else begin
            if (burst_end) begin
              burst_cnt_next = '0;
              bursts_next    = bursts_reg + CNT_ONE;
              gap_sel        = ibg_reg;
            end else begin
              burst_cnt_next = burst_cnt_inc;
              gap_sel        = ifg_reg;
            end
            if (gap_sel == '0) begin
              state_next = ST_REQ;
            end else begin
              gap_cnt_next = gap_sel - GAP_ONE;
              state_next   = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (!run) begin
          state_next = ST_IDLE;
        end else if (gap_cnt_reg == '0) begin
          state_next = ST_REQ;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_ONE;
        end
      end

      ST_DONE: begin
        if (!run) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign emit.frame_req = (state_reg == ST_REQ);
  assign busy           = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done           = (state_reg == ST_DONE);
  assign frames_sent    = frames_reg;
  assign bursts_sent    = bursts_reg;
  assign protocol_err   = err_reg;

endmodule

// File: tb/tb_traffic_generator_burst_scheduler.sv
// Directed bench: emitter model answers requests, a scoreboard checks the
// done-to-request gap of every frame, status is checked at key points.
module tb_traffic_generator_burst_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [31:0] interframe_gap, interburst_gap, frames_per_burst, total_frames;
  logic        busy, done, protocol_err;
  logic [31:0] frames_sent, bursts_sent;

  logic emu_ack = 1'b0, emu_done = 1'b0;
  logic spur_ack = 1'b0, spur_done = 1'b0;

  traffic_generator_burst_scheduler_if emit_if ();
  assign emit_if.frame_ack  = emu_ack  | spur_ack;
  assign emit_if.frame_done = emu_done | spur_done;

  traffic_generator_burst_scheduler #(
    .C_GAP_WIDTH   (32),
    .C_COUNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .run              (run),
    .interframe_gap   (interframe_gap),
    .interburst_gap   (interburst_gap),
    .frames_per_burst (frames_per_burst),
    .total_frames     (total_frames),
    .emit             (emit_if),
    .busy             (busy),
    .done             (done),
    .frames_sent      (frames_sent),
    .bursts_sent      (bursts_sent),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Emitter model
  logic emu_en    = 1'b0;
  int   ack_delay = 1;
  int   done_delay = 10;
  int   emu_limit = 1000000;
  int   ack_count = 0;
  int   emu_phase = 0;
  int   emu_cnt   = 0;

  initial begin
    forever begin
      @(negedge clk);
      emu_ack  = 1'b0;
      emu_done = 1'b0;
      if (!emu_en) begin
        emu_phase = 0;
        emu_cnt   = 0;
      end else if (emu_phase == 0) begin
        if (emit_if.frame_req && ack_count < emu_limit) begin
          if (emu_cnt == ack_delay) begin
            emu_ack   = 1'b1;
            ack_count++;
            emu_phase = 1;
            emu_cnt   = 0;
          end else begin
            emu_cnt++;
          end
        end else begin
          emu_cnt = 0;
        end
      end else begin
        emu_cnt++;
        if (emu_cnt >= done_delay) begin
          emu_done  = 1'b1;
          emu_phase = 0;
          emu_cnt   = 0;
        end
      end
    end
  end

  // Scoreboard: expected done->req gaps, consumed by the monitor
  int   exp_gaps[$];
  int   edge_cnt  = 0;
  int   done_edge = 0;
  logic have_done = 1'b0;
  logic req_prev  = 1'b0;
  int   gap_idx   = 0;

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (resetn && emit_if.frame_done && dut.state_reg == dut.ST_WAIT_DONE) begin
        done_edge = edge_cnt;
        have_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (emit_if.frame_req && !req_prev && have_done) begin
        have_done = 1'b0;
        gap_idx++;
        if (exp_gaps.size() == 0) begin
          n_checks++;
          $display("FAIL gap_unexpected #%0d: got gap %0d, expected no request", gap_idx,
                   edge_cnt - done_edge);
        end else begin
          int e;
          e = exp_gaps.pop_front();
          n_checks++;
          if (edge_cnt - done_edge == e) begin
            n_pass++;
            $display("gap #%0d: measured %0d expected %0d", gap_idx, edge_cnt - done_edge, e);
          end else begin
            $display("FAIL gap #%0d: got %0d, expected %0d", gap_idx, edge_cnt - done_edge, e);
          end
        end
      end
      req_prev = emit_if.frame_req;
    end
  end

  task automatic start_run();
    @(negedge clk);
    have_done = 1'b0;
    run = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cfg(input int tot, input int fpb, input int ifg, input int ibg);
    total_frames     = tot;
    frames_per_burst = fpb;
    interframe_gap   = ifg;
    interburst_gap   = ibg;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_frames(input string name, input int n, input int budget);
    for (int i = 0; i < budget && frames_sent != n; i++) @(negedge clk);
    chk(name, frames_sent, n);
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    for (int i = 0; i < budget && ack_count != n; i++) @(negedge clk);
    chk(name, ack_count, n);
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, emit_if.frame_req}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_bursts", bursts_sent, 0);
    chk("rst_err", {31'd0, protocol_err}, 0);
    resetn = 1'b1;

    // 1: three frames, single unbounded burst, ifg=4
    set_cfg(3, 0, 4, 0);
    ack_delay = 1; done_delay = 10; ack_count = 0; emu_en = 1'b1;
    exp_gaps.push_back(4); exp_gaps.push_back(4);
    start_run();
    @(negedge clk);
    chk("t1_req_start", {31'd0, emit_if.frame_req}, 1);
    wait_done("t1_done", 2000);
    chk("t1_frames", frames_sent, 3);
    chk("t1_bursts", bursts_sent, 0);
    chk("t1_acks", ack_count, 3);
    chk("t1_busy", {31'd0, busy}, 0);
    stop_run();
    chk("t1_idle_done", {31'd0, done}, 0);
    chk("t1_idle_hold", frames_sent, 3);

    // 5a: spurious frame_done in IDLE
    emu_en = 1'b0;
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    chk("t5_err_done", {31'd0, protocol_err}, 1);
    chk("t5_frames_hold", frames_sent, 3);

    // 2: six frames in bursts of two, ifg=2, ibg=20
    set_cfg(6, 2, 2, 20);
    ack_count = 0; emu_en = 1'b1;
    exp_gaps.push_back(2); exp_gaps.push_back(20); exp_gaps.push_back(2);
    exp_gaps.push_back(20); exp_gaps.push_back(2);
    start_run();
    @(negedge clk);
    chk("t2_err_cleared", {31'd0, protocol_err}, 0);
    chk("t2_frames_cleared", frames_sent, 0);
    wait_done("t2_done", 3000);
    chk("t2_frames", frames_sent, 6);
    chk("t2_bursts", bursts_sent, 3);
    chk("t2_acks", ack_count, 6);
    stop_run();

    // 5b: spurious frame_ack during GAP
    set_cfg(2, 0, 30, 0);
    ack_count = 0;
    exp_gaps.push_back(30);
    start_run();
    wait_frames("t5_frame1", 1, 500);
    repeat (3) @(negedge clk);
    chk("t5_in_gap_req", {31'd0, emit_if.frame_req}, 0);
    spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    chk("t5_err_ack", {31'd0, protocol_err}, 1);
    chk("t5_gap_frames", frames_sent, 1);
    chk("t5_gap_busy", {31'd0, busy}, 1);
    wait_done("t5_done", 500);
    chk("t5_frames", frames_sent, 2);
    chk("t5_err_sticky", {31'd0, protocol_err}, 1);
    stop_run();
    chk("t5_err_idle", {31'd0, protocol_err}, 1);

    // 4: run dropped during WAIT_DONE of frame 2 of 5
    set_cfg(5, 0, 3, 0);
    ack_count = 0; done_delay = 10;
    exp_gaps.push_back(3);
    start_run();
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, protocol_err}, 0);
    wait_acks("t4_ack2", 2, 500);
    run = 1'b0;
    wait_frames("t4_frame2", 2, 500);
    repeat (20) @(negedge clk);
    chk("t4_idle_busy", {31'd0, busy}, 0);
    chk("t4_no_req", {31'd0, emit_if.frame_req}, 0);
    chk("t4_acks", ack_count, 2);
    chk("t4_frames", frames_sent, 2);
    chk("t4_not_done", {31'd0, done}, 0);
    emu_en = 1'b0;
    start_run();
    @(negedge clk);
    chk("t4_restart_req", {31'd0, emit_if.frame_req}, 1);
    chk("t4_restart_frames", frames_sent, 0);
    stop_run();

    // 3: continuous, ifg=0, instant ack, 100 frames
    set_cfg(0, 0, 0, 0);
    ack_count = 0; ack_delay = 0; done_delay = 2; emu_limit = 100; emu_en = 1'b1;
    for (int i = 0; i < 100; i++) exp_gaps.push_back(0);
    start_run();
    wait_frames("t3_frames100", 100, 2000);
    repeat (2) @(negedge clk);
    chk("t3_req_held", {31'd0, emit_if.frame_req}, 1);
    run = 1'b0;
    @(negedge clk);
    chk("t3_drop_req", {31'd0, emit_if.frame_req}, 0);
    chk("t3_drop_busy", {31'd0, busy}, 0);
    chk("t3_frames", frames_sent, 100);
    emu_en = 1'b0; emu_limit = 1000000;

    // 6: reset mid-GAP after seven frames
    set_cfg(0, 0, 10, 0);
    ack_count = 0; ack_delay = 1; done_delay = 2; emu_en = 1'b1;
    for (int i = 0; i < 6; i++) exp_gaps.push_back(10);
    start_run();
    wait_frames("t6_frames7", 7, 1000);
    resetn = 1'b0; emu_en = 1'b0; have_done = 1'b0;
    @(negedge clk);
    chk("t6_rst_req", {31'd0, emit_if.frame_req}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_frames", frames_sent, 0);
    chk("t6_rst_bursts", bursts_sent, 0);
    chk("t6_rst_done", {31'd0, done}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_req_after_rst", {31'd0, emit_if.frame_req}, 1);
    chk("t6_busy_after_rst", {31'd0, busy}, 1);
    run = 1'b0;
    @(negedge clk);

    chk("gaps_consumed", exp_gaps.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_generator_burst_scheduler.md
Name: traffic_generator_burst_scheduler

Overview:
- Sequences frame emissions for the GMII traffic generator's frame emitter.
- Issues a per-frame request/acknowledge handshake and waits for end-of-frame.
- Inserts the interframe gap between frames of a burst and the interburst gap between bursts.
- Stops after total_frames, or runs continuously; exposes progress counters to the CPU register block.

Parameters:
C_GAP_WIDTH, 32, width of gap configuration and gap counter (clock cycles)
C_COUNT_WIDTH, 32, width of frame/burst configuration and status counters

Ports:
clk  in  1  core clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
run  in  1  enable level from control register bit 0
interframe_gap  in  C_GAP_WIDTH  idle cycles between frames within a burst
interburst_gap  in  C_GAP_WIDTH  idle cycles after last frame of a burst
frames_per_burst  in  C_COUNT_WIDTH  frames per burst; 0 = single unbounded burst
total_frames  in  C_COUNT_WIDTH  frames per run; 0 = continuous
frame_req  out  1  request emitter to start one frame
frame_ack  in  1  emitter accepted request (1-cycle pulse)
frame_done  in  1  emitter sent last byte (1-cycle pulse)
busy  out  1  high in any state except IDLE and DONE
done  out  1  high in DONE
frames_sent  out  C_COUNT_WIDTH  frames completed this run
bursts_sent  out  C_COUNT_WIDTH  complete bursts this run
protocol_err  out  1  sticky: frame_ack/frame_done outside expected state

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE; all outputs 0; internal counters and latched configuration 0.
- Configuration latching: all four config inputs latched on the IDLE->REQ transition; changes mid-run are ignored until the next run.
- IDLE:
  - frame_req=0.
  - If run=1: latch config; clear frames_sent, bursts_sent, burst_cnt and protocol_err; go to REQ.
  - frame_req is high the cycle after run is first sampled high.
- REQ:
  - frame_req=1, held until frame_ack is sampled high; then go to WAIT_DONE and drop frame_req next cycle.
  - run=0 sampled with no ack: go to IDLE, frame_req withdrawn.
  - run=0 and frame_ack in the same cycle: ack wins, go to WAIT_DONE.
- WAIT_DONE:
  - frame_req=0. Waits indefinitely for frame_done; the frame is never aborted.
  - On frame_done: frames_sent+1.
  - Last frame (total!=0 and frames_sent+1==total): go to DONE; no trailing gap.
  - Else if run=0: go to IDLE.
  - Else, end of burst (fpb!=0 and burst_cnt+1==fpb): burst_cnt<=0, bursts_sent+1, G=interburst_gap.
  - Otherwise: burst_cnt+1, G=interframe_gap.
  - G==0: go to REQ (frame_req high the cycle after frame_done).
  - G>0: go to GAP with gap_cnt<=G-1.
- GAP:
  - frame_req=0; gap_cnt decrements each cycle.
  - At gap_cnt==0 go to REQ, so exactly G cycles separate frame_done from frame_req assertion (frame_done at T -> frame_req at T+G+1).
  - run=0: go to IDLE immediately.
- DONE: done=1; frame_req=0; counters hold. run=0: go to IDLE. A new run requires run to be low for at least one cycle.
- Counters:
  - frames_sent and bursts_sent wrap modulo 2^C_COUNT_WIDTH in continuous mode.
  - burst_cnt is internal, same width, compared only against latched fpb.
- protocol_err:
  - Set by frame_ack outside REQ, or frame_done outside WAIT_DONE; such pulses are otherwise ignored.
  - Cleared only by reset or a new run start.
- Status outputs hold their last values in IDLE for CPU readback until the next run starts.

Test Plan:
- total=3, fpb=0, ifg=4, emitter acks 1 cycle after req and gives done 10 cycles after ack -> 3 req/ack cycles; 4 idle cycles between each done and next req; DONE with frames_sent=3, bursts_sent=0, done=1.
- total=6, fpb=2, ifg=2, ibg=20 -> gaps after frames 1..5 are 2,20,2,20,2; final bursts_sent=3 (frames 2,4,6 complete bursts; last without gap); frames_sent=6.
- total=0, ifg=0, fpb=0, instant ack -> frame_req reasserts the cycle after each frame_done; after 100 frames run=0 in GAP/REQ -> IDLE within 1 cycle; frames_sent=100.
- run dropped during WAIT_DONE of frame 2 of 5 -> frame completes; frames_sent=2; state IDLE; no further req; run high again -> counters cleared and req next cycle.
- Spurious frame_done in IDLE and frame_ack during GAP -> protocol_err=1, counters unchanged; stays set until next run start.
- resetn=0 mid-GAP with frames_sent=7 -> next cycle all outputs 0, state IDLE; run held high -> req the cycle after resetn returns high.
